// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   Fully synchronous modulo-(LIMIT+1) up/down counter. Every bit of the count
//   changes on the same rising clk edge, so stages can be cascaded by feeding
//   en & tc of one stage into en of the next without any ripple delay.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   LIMIT     highest count value; the count range is 0..LIMIT
//   SATURATE  0 = wrap around at the ends, 1 = hold at the ends
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (q=0, wrap=0)
//   en        in   count enable
//   load      in   parallel load strobe (has priority over en)
//   load_val  in   value to load, clamped to LIMIT
//   up        in   direction: 1 = up, 0 = down
//   q         out  registered count
//   q_bar     out  bitwise complement of q
//   tc        out  terminal count for the current direction (combinational)
//   wrap      out  registered one-cycle pulse after a wrapping edge
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int LIMIT    = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LimitV = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  // Next-state logic: load beats en beats hold. Loads are clamped so the
  // counter can never hold a value above LIMIT, which is what lets the
  // end-of-range tests below use plain equality.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > LimitV) ? LimitV : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q == LimitV) begin
          if (SATURATE == 0) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q == '0) begin
          if (SATURATE == 0) begin
            count_d = LimitV;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // tc tracks the direction input with no latency so a cascaded stage sees
  // a direction change on the same cycle.
  assign q     = count_q;
  assign q_bar = ~count_q;
  assign tc    = up ? (count_q == LimitV) : (count_q == '0);
  assign wrap  = wrap_q;

endmodule
